core_clken_gen: RTL

CORE_CLKEN_GEN -- requirements
Module: core_clken_gen

---
 rtl/core_clken_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/core_clken_gen.sv
// core_clken_gen: multi-channel phase-accumulator clock-enable generator with shadowed config and lock tracking.
// Build option: define CLKEN_HALF_EN to generate the half-period ce_half pulses (tied low otherwise).
module core_clken_gen #(
  parameter int CHANNELS    = 4,
  parameter int ACC_W       = 16,
  parameter int LOCK_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [2:0]          cfg_ch,
  input  logic [ACC_W-1:0]    cfg_inc,
  input  logic [ACC_W-1:0]    cfg_phase,
  input  logic                cfg_commit,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] ce_half,
  output logic                locked
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOCKED = 2'd1,
    APPLY  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             locked_reg;
  logic             cfg_err_reg;
  logic             wr_fire;
  logic             commit_fire;
  logic             ch_bad;

  // Writes are only blocked in the single APPLY cycle; reset forces ready high.
  assign cfg_ready   = (state_reg != APPLY) || !reset_n;
  assign wr_fire     = cfg_valid && cfg_ready;
  assign commit_fire = cfg_commit && (state_reg != APPLY);
  assign ch_bad      = ({1'b0, cfg_ch} >= 4'(CHANNELS));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      SETTLE: begin
        if (commit_fire) begin
          state_next = APPLY;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = LOCKED;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (commit_fire) begin
          state_next = APPLY;
          cnt_next   = '0;
        end
      end
      APPLY: begin
        state_next = SETTLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = SETTLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= SETTLE;
      cnt_reg     <= '0;
      locked_reg  <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      locked_reg  <= (state_next == LOCKED);
      cfg_err_reg <= wr_fire && ch_bad;
    end
  end

  assign locked  = locked_reg;
  assign cfg_err = cfg_err_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [ACC_W-1:0] sh_inc_reg;
      logic [ACC_W-1:0] sh_phase_reg;
      logic [ACC_W-1:0] act_inc_reg;
      logic [ACC_W-1:0] act_phase_reg;
      logic [ACC_W-1:0] acc_reg;
      logic [ACC_W-1:0] sh_inc_next;
      logic [ACC_W-1:0] sh_phase_next;
      logic [ACC_W:0]   sum;
      logic             wr_hit;
      logic             ce_reg;
      logic             unused_act_phase;

      assign wr_hit = wr_fire && (cfg_ch == 3'(gi));

      // A write landing on the commit edge is forwarded straight into the active set.
      assign sh_inc_next   = wr_hit ? cfg_inc   : sh_inc_reg;
      assign sh_phase_next = wr_hit ? cfg_phase : sh_phase_reg;
      assign sum           = {1'b0, acc_reg} + {1'b0, act_inc_reg};

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          sh_inc_reg    <= '0;
          sh_phase_reg  <= '0;
          act_inc_reg   <= '0;
          act_phase_reg <= '0;
          acc_reg       <= '0;
          ce_reg        <= 1'b0;
        end else begin
          sh_inc_reg   <= sh_inc_next;
          sh_phase_reg <= sh_phase_next;
          if (commit_fire) begin
            act_inc_reg   <= sh_inc_next;
            act_phase_reg <= sh_phase_next;
            acc_reg       <= sh_phase_next;
            ce_reg        <= 1'b0;
          end else begin
            acc_reg <= sum[ACC_W-1:0];
            ce_reg  <= sum[ACC_W];
          end
        end
      end

      assign ce[gi] = ce_reg;

      // The active phase is architectural state only; the accumulator is the live phase.
      assign unused_act_phase = ^act_phase_reg;

`ifdef CLKEN_HALF_EN
      logic half_reg;

      always_ff @(posedge clk) begin
        if (!reset_n || commit_fire) begin
          half_reg <= 1'b0;
        end else begin
          half_reg <= !acc_reg[ACC_W-1] && sum[ACC_W-1];
        end
      end

      assign ce_half[gi] = half_reg;
`else
      assign ce_half[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule
